arm_multicycle_ctrl: RTL

Multicycle control unit for the ARMv4 subset: DP (ADD/SUB/AND/ORR/EOR/CMP/TST/MOV), LDR/STR, B.
- Replaces the single-cycle controller/condlogic pair.
- Drives a shared-memory datapath through a state machine.
- Adds a memory-ready handshake, a bounded wait timeout, a FAULT state, and a parametrised ALU-control width.
- Holds the NZCV flag register internally.

---
 rtl/arm_ctrl_pkg.sv | 99 +++++++++
 rtl/arm_cond_unit.sv | 58 +++++
 rtl/arm_multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared types and encodings for the ARMv4-subset multicycle controller.
//   state_t          controller FSM states
//   ALU_*            ALU operation codes (zero-extended to ALU_CTRL_W at the top)
//   COND_*           condition-code field values
//   CMD_*            data-processing cmd field values (funct[4:1])
//   SRCB_* / RES_*   alu_src_b and result_src mux encodings
//   dp_decode()      maps a data-processing cmd to ALU op and write/flag behaviour
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StFault
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b110;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;
    localparam logic [1:0] RES_SRCB    = 2'b11;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       writes_rd;
        logic       nz_upd;
        logic       cv_upd;
        logic       is_mov;
    } dp_ctrl_t;

    // Undefined cmds fall through to ADD with no register or flag side effects.
    function automatic dp_ctrl_t dp_decode(input logic [3:0] cmd);
        dp_ctrl_t d;
        d = '{alu_op: ALU_ADD, writes_rd: 1'b0, nz_upd: 1'b0, cv_upd: 1'b0, is_mov: 1'b0};
        case (cmd)
            CMD_ADD: d = '{alu_op: ALU_ADD, writes_rd: 1'b1, nz_upd: 1'b1, cv_upd: 1'b1,
                           is_mov: 1'b0};
            CMD_SUB: d = '{alu_op: ALU_SUB, writes_rd: 1'b1, nz_upd: 1'b1, cv_upd: 1'b1,
                           is_mov: 1'b0};
            CMD_CMP: d = '{alu_op: ALU_SUB, writes_rd: 1'b0, nz_upd: 1'b1, cv_upd: 1'b1,
                           is_mov: 1'b0};
            CMD_AND: d = '{alu_op: ALU_AND, writes_rd: 1'b1, nz_upd: 1'b1, cv_upd: 1'b0,
                           is_mov: 1'b0};
            CMD_TST: d = '{alu_op: ALU_AND, writes_rd: 1'b0, nz_upd: 1'b1, cv_upd: 1'b0,
                           is_mov: 1'b0};
            CMD_ORR: d = '{alu_op: ALU_ORR, writes_rd: 1'b1, nz_upd: 1'b1, cv_upd: 1'b0,
                           is_mov: 1'b0};
            CMD_EOR: d = '{alu_op: ALU_EOR, writes_rd: 1'b1, nz_upd: 1'b1, cv_upd: 1'b0,
                           is_mov: 1'b0};
            CMD_MOV: d = '{alu_op: ALU_ADD, writes_rd: 1'b1, nz_upd: 1'b1, cv_upd: 1'b0,
                           is_mov: 1'b1};
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/arm_cond_unit.sv
// arm_cond_unit: condition-code check against the NZCV register, plus that register.
//   clk, reset      clock, asynchronous active-high reset (flags clear to 0)
//   cond            instruction condition field
//   alu_flags       NZCV from the ALU this cycle
//   nz_we, cv_we    write enables for the N/Z and C/V flag groups
//   flags           current NZCV register
//   cond_ok         condition passes (0 for the NV encoding)
module arm_cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       nz_we,
    input  logic       cv_we,
    output logic [3:0] flags,
    output logic       cond_ok
);

    logic [3:0] flags_q;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;
    assign flags = flags_q;

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            COND_EQ: cond_ok = z;
            COND_NE: cond_ok = ~z;
            COND_CS: cond_ok = c;
            COND_CC: cond_ok = ~c;
            COND_MI: cond_ok = n;
            COND_PL: cond_ok = ~n;
            COND_VS: cond_ok = v;
            COND_VC: cond_ok = ~v;
            COND_HI: cond_ok = c & ~z;
            COND_LS: cond_ok = ~c | z;
            COND_GE: cond_ok = (n == v);
            COND_LT: cond_ok = (n != v);
            COND_GT: cond_ok = ~z & (n == v);
            COND_LE: cond_ok = z | (n != v);
            COND_AL: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            if (nz_we) flags_q[3:2] <= alu_flags[3:2];
            if (cv_we) flags_q[1:0] <= alu_flags[1:0];
        end
    end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl: multicycle controller for the ARMv4 subset (DP, LDR/STR, B).
//   clk, reset       clock, asynchronous active-high reset
//   instr            instruction bits [31:12]
//   alu_flags        NZCV from the ALU this cycle
//   mem_ready        memory completes the requested access this cycle
//   mem_req/mem_write, adr_src, ir_write, pc_write, reg_write   datapath strobes/selects
//   reg_src, imm_src, alu_src_a, alu_src_b, result_src, alu_control   datapath controls
//   flags            current NZCV register
//   fault            controller is in FAULT (held until reset)
// Optional: define PERF_COUNTERS_EN to add retired[31:0] and stall_cycles[31:0].
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 3,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [19:0]           instr,
    input  logic [3:0]            alu_flags,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            reg_src,
    output logic [1:0]            imm_src,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
`ifdef PERF_COUNTERS_EN
    output logic [31:0]           retired,
    output logic [31:0]           stall_cycles,
`endif
    output logic [3:0]            flags,
    output logic                  fault
);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] alu_op;
    logic       nz_we, cv_we, cond_ok;
    logic       waiting, timeout_hit;
    dp_ctrl_t   dp;

    // instr[19:0] = instruction[31:12]
    logic [3:0] cond;
    logic [1:0] op;
    logic       i_bit, s_bit;
    logic [3:0] cmd, rd;
    logic       unused_rn;

    assign cond      = instr[19:16];
    assign op        = instr[15:14];
    assign i_bit     = instr[13];
    assign cmd       = instr[12:9];
    assign s_bit     = instr[8];   // also L for memory instructions
    assign rd        = instr[3:0];
    assign unused_rn = ^instr[7:4];
    assign dp        = dp_decode(cmd);

    assign alu_control = ALU_CTRL_W'(alu_op);

    arm_cond_unit u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (cond),
        .alu_flags (alu_flags),
        .nz_we     (nz_we),
        .cv_we     (cv_we),
        .flags     (flags),
        .cond_ok   (cond_ok)
    );

    // The timeout cycle itself drops mem_req so no access is half-issued on the way to FAULT.
    assign waiting     = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    assign timeout_hit = waiting && !mem_ready && (cnt_q == 8'(TIMEOUT - 1));
    assign cnt_d       = (waiting && !mem_ready && !timeout_hit) ? cnt_q + 8'd1 : 8'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg_src    = 2'b00;
        imm_src    = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        result_src = RES_ALUOUT;
        alu_op     = ALU_ADD;
        nz_we      = 1'b0;
        cv_we      = 1'b0;
        fault      = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (timeout_hit) begin
                    state_d = StFault;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        alu_src_a  = 1'b1;
                        alu_src_b  = SRCB_FOUR;
                        result_src = RES_ALU;
                        state_d    = StDecode;
                    end
                end
            end
            StDecode: begin
                if (cond == COND_NV) begin
                    state_d = StFault;
                end else if (!cond_ok) begin
                    state_d = StFetch;
                end else begin
                    case (op)
                        2'b01:   state_d = StMemAdr;
                        2'b00:   state_d = i_bit ? StExecI : StExecR;
                        2'b10:   state_d = StBranch;
                        default: state_d = StFault;
                    endcase
                end
            end
            StMemAdr: begin
                alu_src_b = SRCB_IMM;
                imm_src   = 2'b01;
                state_d   = s_bit ? StMemRd : StMemWr;
            end
            StMemRd: begin
                if (timeout_hit) begin
                    state_d = StFault;
                end else begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) state_d = StMemWb;
                end
            end
            StMemWb: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
                pc_write   = (rd == 4'hF);
                state_d    = StFetch;
            end
            StMemWr: begin
                if (timeout_hit) begin
                    state_d = StFault;
                end else begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    reg_src   = 2'b10;
                    if (mem_ready) state_d = StFetch;
                end
            end
            StExecR, StExecI: begin
                alu_op    = dp.alu_op;
                alu_src_b = i_bit ? SRCB_IMM : SRCB_REG;
                state_d   = StAluWb;
            end
            StAluWb: begin
                // Keep the ALU inputs stable so alu_flags and SrcB reflect this instruction.
                alu_op     = dp.alu_op;
                alu_src_b  = i_bit ? SRCB_IMM : SRCB_REG;
                reg_write  = dp.writes_rd;
                pc_write   = dp.writes_rd && (rd == 4'hF);
                result_src = dp.is_mov ? RES_SRCB : RES_ALUOUT;
                nz_we      = s_bit && dp.nz_upd;
                cv_we      = s_bit && dp.cv_upd;
                state_d    = StFetch;
            end
            StBranch: begin
                imm_src    = 2'b10;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                pc_write   = 1'b1;
                state_d    = StFetch;
            end
            StFault: begin
                fault = 1'b1;
            end
            default: begin
                state_d = StFault;
            end
        endcase

        // Strobes must be quiet for the whole reset window, including mid-cycle assertion.
        if (reset) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            nz_we     = 1'b0;
            cv_we     = 1'b0;
        end
    end

`ifdef PERF_COUNTERS_EN
    logic retire;

    assign retire = (state_d == StFetch) &&
                    ((state_q == StDecode) || (state_q == StMemWb) || (state_q == StMemWr) ||
                     (state_q == StAluWb) || (state_q == StBranch));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired      <= '0;
            stall_cycles <= '0;
        end else begin
            if (retire)                stall_cycles <= stall_cycles;
            if (retire)                retired      <= retired + 32'd1;
            if (mem_req && !mem_ready) stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
